// File: rtl/l2_cache_dir.sv
// l2_cache_dir -- directory stage of the L2 pipeline.
//   Sits between the tag-check stage and the data-read stage. It compares the
//   four way tags against the request tag to produce hit and hit way. It owns
//   the per-set/per-way dirty array and reports the set's dirty bits as they
//   were before this request's update. It also picks the victim way and reports
//   the victim's old tag for writeback. The whole request is registered one
//   stage, and every register holds while stall_pipeline is high.
// Ports:
//   clk, reset (async, active high), stall_pipeline
//   tag_*  : request, fill info and way tags/valids from the tag stage
//   dir_*  : registered request, hit/victim info and pre-update dirty bits
module l2_cache_dir #(
  parameter int NUM_SETS        = 128,
  parameter int SET_INDEX_WIDTH = 7,
  parameter int TAG_WIDTH       = 19
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 stall_pipeline,
  input  logic                                 tag_l2req_valid,
  input  logic [1:0]                           tag_l2req_unit,
  input  logic [1:0]                           tag_l2req_strand,
  input  logic [2:0]                           tag_l2req_op,
  input  logic [1:0]                           tag_l2req_way,
  input  logic [TAG_WIDTH+SET_INDEX_WIDTH-1:0] tag_l2req_address,
  input  logic [511:0]                         tag_l2req_data,
  input  logic [63:0]                          tag_l2req_mask,
  input  logic                                 tag_has_sm_data,
  input  logic [511:0]                         tag_sm_data,
  input  logic [1:0]                           tag_sm_fill_l2_way,
  input  logic [1:0]                           tag_replace_l2_way,
  input  logic [TAG_WIDTH-1:0]                 tag_l2_tag0,
  input  logic [TAG_WIDTH-1:0]                 tag_l2_tag1,
  input  logic [TAG_WIDTH-1:0]                 tag_l2_tag2,
  input  logic [TAG_WIDTH-1:0]                 tag_l2_tag3,
  input  logic                                 tag_l2_valid0,
  input  logic                                 tag_l2_valid1,
  input  logic                                 tag_l2_valid2,
  input  logic                                 tag_l2_valid3,
  output logic                                 dir_l2req_valid,
  output logic [1:0]                           dir_l2req_unit,
  output logic [1:0]                           dir_l2req_strand,
  output logic [2:0]                           dir_l2req_op,
  output logic [1:0]                           dir_l2req_way,
  output logic [TAG_WIDTH+SET_INDEX_WIDTH-1:0] dir_l2req_address,
  output logic [511:0]                         dir_l2req_data,
  output logic [63:0]                          dir_l2req_mask,
  output logic                                 dir_has_sm_data,
  output logic [511:0]                         dir_sm_data,
  output logic [1:0]                           dir_sm_fill_l2_way,
  output logic                                 dir_cache_hit,
  output logic [1:0]                           dir_hit_l2_way,
  output logic [1:0]                           dir_replace_l2_way,
  output logic [TAG_WIDTH-1:0]                 dir_old_l2_tag,
  output logic                                 dir_l2_dirty0,
  output logic                                 dir_l2_dirty1,
  output logic                                 dir_l2_dirty2,
  output logic                                 dir_l2_dirty3
);
  localparam logic [2:0] OP_LOAD       = 3'd0;
  localparam logic [2:0] OP_STORE      = 3'd1;
  localparam logic [2:0] OP_FLUSH      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
  localparam logic [2:0] OP_STORE_SYNC = 3'd5;

  logic [NUM_SETS-1:0][3:0]      r_dirty;
  logic [3:0][TAG_WIDTH-1:0]     w_way_tag;
  logic [3:0]                    w_way_valid;
  logic [SET_INDEX_WIDTH-1:0]    w_set;
  logic [TAG_WIDTH-1:0]          w_req_tag;
  logic [3:0]                    w_match;
  logic [1:0]                    w_lowest;
  logic                          w_hit;
  logic [1:0]                    w_hit_way;
  logic [1:0]                    w_victim;
  logic [3:0]                    w_dirty_rd;
  logic                          w_is_store;
  logic                          w_upd_en;
  logic [1:0]                    w_upd_way;
  logic                          w_upd_val;

  assign w_way_tag   = {tag_l2_tag3, tag_l2_tag2, tag_l2_tag1, tag_l2_tag0};
  assign w_way_valid = {tag_l2_valid3, tag_l2_valid2, tag_l2_valid1, tag_l2_valid0};
  assign w_set       = tag_l2req_address[SET_INDEX_WIDTH-1:0];
  assign w_req_tag   = tag_l2req_address[TAG_WIDTH+SET_INDEX_WIDTH-1:SET_INDEX_WIDTH];

  for (genvar g = 0; g < 4; g++) begin : g_way
    assign w_match[g] = w_way_valid[g] && (w_way_tag[g] == w_req_tag);
  end

  // Lowest matching way wins; descending scan leaves the smallest index.
  always_comb begin
    w_lowest = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (w_match[i]) w_lowest = 2'(i);
  end

  // A restarted fill is a hit by construction, in the way being filled.
  assign w_hit      = tag_has_sm_data | (|w_match);
  assign w_hit_way  = tag_has_sm_data ? tag_sm_fill_l2_way : w_lowest;
  assign w_victim   = tag_has_sm_data ? tag_sm_fill_l2_way : tag_replace_l2_way;
  assign w_dirty_rd = r_dirty[w_set];
  assign w_is_store = (tag_l2req_op == OP_STORE) || (tag_l2req_op == OP_STORE_SYNC);

  // At most one way of the request's set changes per accepted request.
  always_comb begin
    w_upd_en  = 1'b0;
    w_upd_way = w_hit_way;
    w_upd_val = 1'b0;
    if (tag_l2req_valid && !stall_pipeline) begin
      if (tag_has_sm_data) begin
        w_upd_en  = 1'b1;
        w_upd_val = w_is_store;
      end else if (|w_match) begin
        unique case (tag_l2req_op)
          OP_STORE, OP_STORE_SYNC:    begin w_upd_en = 1'b1; w_upd_val = 1'b1; end
          OP_FLUSH, OP_INVALIDATE:    begin w_upd_en = 1'b1; w_upd_val = 1'b0; end
          OP_LOAD, OP_LOAD_SYNC:      w_upd_en = 1'b0;
          default:                    w_upd_en = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_dirty <= '0;
    else if (w_upd_en) r_dirty[w_set][w_upd_way] <= w_upd_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_l2req_valid    <= 1'b0;
      dir_l2req_unit     <= '0;
      dir_l2req_strand   <= '0;
      dir_l2req_op       <= '0;
      dir_l2req_way      <= '0;
      dir_l2req_address  <= '0;
      dir_l2req_data     <= '0;
      dir_l2req_mask     <= '0;
      dir_has_sm_data    <= 1'b0;
      dir_sm_data        <= '0;
      dir_sm_fill_l2_way <= '0;
      dir_cache_hit      <= 1'b0;
      dir_hit_l2_way     <= '0;
      dir_replace_l2_way <= '0;
      dir_old_l2_tag     <= '0;
      dir_l2_dirty0      <= 1'b0;
      dir_l2_dirty1      <= 1'b0;
      dir_l2_dirty2      <= 1'b0;
      dir_l2_dirty3      <= 1'b0;
    end else if (!stall_pipeline) begin
      dir_l2req_valid    <= tag_l2req_valid;
      dir_l2req_unit     <= tag_l2req_unit;
      dir_l2req_strand   <= tag_l2req_strand;
      dir_l2req_op       <= tag_l2req_op;
      dir_l2req_way      <= tag_l2req_way;
      dir_l2req_address  <= tag_l2req_address;
      dir_l2req_data     <= tag_l2req_data;
      dir_l2req_mask     <= tag_l2req_mask;
      dir_has_sm_data    <= tag_has_sm_data;
      dir_sm_data        <= tag_sm_data;
      dir_sm_fill_l2_way <= tag_sm_fill_l2_way;
      dir_cache_hit      <= w_hit;
      dir_hit_l2_way     <= w_hit_way;
      dir_replace_l2_way <= w_victim;
      dir_old_l2_tag     <= w_way_tag[w_victim];
      dir_l2_dirty0      <= w_dirty_rd[0];
      dir_l2_dirty1      <= w_dirty_rd[1];
      dir_l2_dirty2      <= w_dirty_rd[2];
      dir_l2_dirty3      <= w_dirty_rd[3];
    end
  end

  // A tag duplicated across ways means the tag stage is corrupt.
  always_ff @(posedge clk) begin
    if (!reset && tag_l2req_valid && !tag_has_sm_data)
      assert ($onehot0(w_match));
  end
endmodule
